// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised two-cycle accumulator CPU with loadable program memory
module acc_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W+3:0] prog_data,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);
   localparam int RW = $clog2(NREG);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
   state_t state, state_n;
   logic [DATA_W+3:0] mem [2**ADDR_W];
   logic [DATA_W+3:0] ir;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] acc, acc_n, rv, opnd;
   logic [3:0] op;
   logic [RW-1:0] ridx;
   logic [ADDR_W-1:0] pc_n;
   logic z, c, z_n, c_n, acc_wr;
   assign op = ir[DATA_W+3:DATA_W];
   assign opnd = ir[DATA_W-1:0];
   assign ridx = opnd[RW-1:0];
   assign rv = regs[ridx];
   assign halted = state == HALT;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = run ? FETCH : IDLE;
         FETCH:   state_n = EXEC;
         EXEC:    state_n = op == 4'hF ? HALT : run ? FETCH : IDLE;
         default: state_n = run ? HALT : IDLE;
      endcase
   end
   // acc_wr marks ops whose result drives Z; acc_n equals acc for all others
   always_comb begin
      acc_n = acc;
      c_n = c;
      acc_wr = 1'b1;
      pc_n = pc + 1'b1;
      case (op)
         4'h1: acc_n = opnd;
         4'h2: {c_n, acc_n} = {1'b0, acc} + {1'b0, opnd};
         4'h3: {c_n, acc_n} = {1'b0, acc} - {1'b0, opnd};
         4'h4: {c_n, acc_n} = {1'b0, acc} + {1'b0, rv};
         4'h5: {c_n, acc_n} = {1'b0, acc} - {1'b0, rv};
         4'h6: acc_n = acc & rv;
         4'h7: acc_n = acc | rv;
         4'h8: acc_n = acc ^ rv;
         4'hA: acc_n = rv;
         4'hB: if (opnd[0]) {acc_n, c_n} = {1'b0, acc}; else {c_n, acc_n} = {acc, 1'b0};
         4'hC: begin
            acc_wr = 1'b0;
            pc_n = opnd[ADDR_W-1:0];
         end
         4'hD: begin
            acc_wr = 1'b0;
            if (z) pc_n = opnd[ADDR_W-1:0];
         end
         4'hE: begin
            acc_wr = opnd[0];
            if (opnd[0]) acc_n = in_data;
         end
         4'hF: begin
            acc_wr = 1'b0;
            pc_n = pc;
         end
         default: acc_wr = 1'b0;
      endcase
      z_n = acc_wr ? acc_n == '0 : z;
   end
   always_ff @(posedge clk)
      if (prog_we && (state == IDLE || state == HALT)) mem[prog_addr] <= prog_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc <= '0;
         acc <= '0;
         z <= 1'b0;
         c <= 1'b0;
         ir <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         state <= state_n;
         out_valid <= 1'b0;
         if (state == FETCH) ir <= mem[pc];
         if (state == EXEC) begin
            acc <= acc_n;
            z <= z_n;
            c <= c_n;
            pc <= pc_n;
            if (op == 4'h9) regs[ridx] <= acc;
            if (op == 4'hE && !opnd[0]) begin
               out_data <= acc;
               out_valid <= 1'b1;
            end
         end
         if (state == HALT && !run) pc <= '0;
      end
   end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed programs with an output scoreboard for acc_cpu_core
module tb_acc_cpu_core;
   logic clk = 1'b0, rst = 1'b1, run = 1'b0, prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [11:0] prog_data = '0;
   logic [7:0] in_data = 8'hA5;
   logic [7:0] out_data;
   logic out_valid, halted;
   logic [3:0] pc;
   int tests = 0, fails = 0, n;
   logic [7:0] exp_q[$];
   logic prev_v = 1'b0;

   acc_cpu_core dut (.clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .halted(halted), .pc(pc));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
         else chk("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
         chk("strobe_width", {31'b0, prev_v}, 0);
      end
      prev_v = out_valid;
   end

   task automatic load(input logic [3:0] a, input logic [3:0] o, input logic [7:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = {o, d};
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic run_prog(output int cyc);
      run = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!halted && cyc < 300);
      chk("halt_reached", {31'b0, halted}, 1);
   endtask

   task automatic stop();
      run = 1'b0;
      @(negedge clk);
      chk("halt_exit_pc", {28'b0, pc}, 0);
      chk("halt_exit_halted", {31'b0, halted}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_pc", {28'b0, pc}, 0);
      chk("rst_out_data", {24'b0, out_data}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_halted", {31'b0, halted}, 0);
      rst = 1'b0;
      @(negedge clk);
      // basic: LDI 5; ADDI 3; OUT; HALT
      load(0, 4'h1, 8'h05); load(1, 4'h2, 8'h03); load(2, 4'hE, 8'h00); load(3, 4'hF, 8'h00);
      exp_q.push_back(8'h08);
      run_prog(n);
      chk("p1_cycles", n, 9);
      chk("p1_pc", {28'b0, pc}, 3);
      chk("p1_out", {24'b0, out_data}, 8'h08);
      stop();
      // carry/zero on ADDI overflow
      load(0, 4'h1, 8'hFF); load(1, 4'h2, 8'h01); load(2, 4'hF, 8'h00);
      run_prog(n);
      chk("addi_acc", {24'b0, dut.acc}, 0);
      chk("addi_z", {31'b0, dut.z}, 1);
      chk("addi_c", {31'b0, dut.c}, 1);
      stop();
      // acc survives halt; SUBI borrow
      load(0, 4'h3, 8'h01); load(1, 4'hE, 8'h00); load(2, 4'hF, 8'h00);
      exp_q.push_back(8'hFF);
      run_prog(n);
      chk("subi_c", {31'b0, dut.c}, 1);
      chk("subi_z", {31'b0, dut.z}, 0);
      stop();
      // register ADD and SHL
      load(0, 4'h1, 8'h07); load(1, 4'h9, 8'h02); load(2, 4'h1, 8'h01); load(3, 4'h4, 8'h02);
      load(4, 4'hB, 8'h00); load(5, 4'hE, 8'h00); load(6, 4'hF, 8'h00);
      exp_q.push_back(8'h10);
      run_prog(n);
      chk("shl_c0", {31'b0, dut.c}, 0);
      stop();
      load(0, 4'h1, 8'h81); load(1, 4'hB, 8'h00); load(2, 4'hE, 8'h00); load(3, 4'hF, 8'h00);
      exp_q.push_back(8'h02);
      run_prog(n);
      chk("shl_c1", {31'b0, dut.c}, 1);
      stop();
      // logic ops, SUB r, IN, SHR, LD
      load(0, 4'h1, 8'h0F); load(1, 4'h9, 8'h01); load(2, 4'h1, 8'h3C); load(3, 4'h6, 8'h01);
      load(4, 4'hE, 8'h00); load(5, 4'h7, 8'h01); load(6, 4'hE, 8'h00); load(7, 4'h8, 8'h01);
      load(8, 4'hE, 8'h00); load(9, 4'h5, 8'h01); load(10, 4'hE, 8'h00); load(11, 4'hE, 8'h01);
      load(12, 4'hE, 8'h00); load(13, 4'hB, 8'h01); load(14, 4'hA, 8'h02); load(15, 4'hF, 8'h00);
      exp_q.push_back(8'h0C); exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
      exp_q.push_back(8'hF1); exp_q.push_back(8'hA5);
      run_prog(n);
      chk("mix_cycles", n, 33);
      chk("mix_acc", {24'b0, dut.acc}, 8'h07);
      chk("mix_c", {31'b0, dut.c}, 1);
      chk("mix_z", {31'b0, dut.z}, 0);
      stop();
      // count-down loop
      load(0, 4'h1, 8'h03); load(1, 4'h3, 8'h01); load(2, 4'hD, 8'h04); load(3, 4'hC, 8'h01);
      load(4, 4'hE, 8'h00); load(5, 4'hF, 8'h00);
      exp_q.push_back(8'h00);
      run_prog(n);
      chk("loop_cycles", n, 23);
      chk("loop_pc", {28'b0, pc}, 5);
      stop();
      // JMP 15, NOP at 15 wraps pc to 0
      load(0, 4'hA, 8'h03); load(1, 4'hD, 8'h03); load(2, 4'hF, 8'h00); load(3, 4'h1, 8'h09);
      load(4, 4'h9, 8'h03); load(5, 4'hE, 8'h00); load(6, 4'hC, 8'h0F); load(15, 4'h0, 8'h00);
      exp_q.push_back(8'h09);
      run_prog(n);
      chk("wrap_cycles", n, 21);
      chk("wrap_pc", {28'b0, pc}, 2);
      stop();
      // pause during EXEC of the OUT at address 2
      load(0, 4'h1, 8'h05); load(1, 4'h2, 8'h03); load(2, 4'hE, 8'h00); load(3, 4'hF, 8'h00);
      exp_q.push_back(8'h08);
      run = 1'b1;
      repeat (6) @(negedge clk);
      chk("pause_exec_pc", {28'b0, pc}, 2);
      run = 1'b0;
      @(negedge clk);
      chk("pause_pc", {28'b0, pc}, 3);
      repeat (2) @(negedge clk);
      chk("pause_hold_pc", {28'b0, pc}, 3);
      chk("pause_halted", {31'b0, halted}, 0);
      load(3, 4'h2, 8'h01); load(4, 4'hE, 8'h00); load(5, 4'hF, 8'h00);
      exp_q.push_back(8'h09);
      run_prog(n);
      chk("resume_cycles", n, 7);
      chk("resume_pc", {28'b0, pc}, 5);
      stop();
      // reset mid-run
      load(3, 4'hF, 8'h00);
      run = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_pc", {28'b0, pc}, 0);
      chk("mrst_out_data", {24'b0, out_data}, 0);
      chk("mrst_out_valid", {31'b0, out_valid}, 0);
      chk("mrst_halted", {31'b0, halted}, 0);
      chk("mrst_acc", {24'b0, dut.acc}, 0);
      rst = 1'b0;
      run = 1'b0;
      @(negedge clk);
      exp_q.push_back(8'h08);
      run_prog(n);
      chk("rerun_cycles", n, 9);
      chk("rerun_out", {24'b0, out_data}, 8'h08);
      stop();
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised accumulator CPU core, successor to the fixed 8-bit tiny_cpu, instantiated inside the top-level Tiny Tapeout wrapper. It has configurable data width, program depth and scratch-register count, and a writable program memory loaded through a port. A run/pause/halt state machine executes one instruction every two cycles. Output writes are flagged with a one-cycle strobe so the wrapper can latch or forward them.

## Interface
- DATA_W, 8: accumulator, register and operand width. Must be ≥ ADDR_W and ≥ clog2(NREG).
- ADDR_W, 4: program counter width. Program memory holds 2^ADDR_W words of (4+DATA_W) bits.
- NREG, 4: number of scratch registers (power of 2, ≥ 2).
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  level. 1 = execute, 0 = pause (or leave HALT).
- prog_we  in  1  program memory write enable. Honoured only in IDLE or HALT.
- prog_addr  in  ADDR_W  program memory write address.
- prog_data  in  4+DATA_W  instruction word: opcode [DATA_W+3:DATA_W], operand [DATA_W-1:0].
- in_data  in  DATA_W  external input, sampled by IN.
- out_data  out  DATA_W  last OUT value.
- out_valid  out  1  one-cycle strobe when out_data is updated.
- halted  out  1  high while in HALT.
- pc  out  ADDR_W  current program counter, for debug.

## Operation
- Reset values: pc=0, acc=0, Z=0, C=0, all regs=0, out_data=0, out_valid=0, halted=0, state=IDLE. Program memory is not reset.
- States:
  - IDLE: run=1 → FETCH.
  - FETCH: ir ← mem[pc] → EXEC.
  - EXEC: execute, update pc. Next state is HALT if the opcode is HALT; otherwise FETCH if run=1, else IDLE.
  - HALT: run=0 → IDLE with pc←0. acc, regs and flags are kept.
- Pause: run dropping mid-instruction completes the current EXEC, then enters IDLE with pc kept. run=1 resumes at that pc.
- prog_we in FETCH/EXEC is ignored. There is no write/fetch collision.
- Opcodes (imm = operand; r = operand[clog2(NREG)-1:0]):
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 ADDI: acc+=imm.
  - 3 SUBI: acc-=imm.
  - 4 ADD r.
  - 5 SUB r.
  - 6 AND r.
  - 7 OR r.
  - 8 XOR r.
  - 9 ST: reg[r]=acc.
  - A LD: acc=reg[r].
  - B SHIFT: operand[0]=0 is SHL, 1 is SHR; zero fill.
  - C JMP: pc=operand[ADDR_W-1:0].
  - D JZ: jump if Z=1.
  - E IO: operand[0]=0 is OUT (out_data=acc, out_valid=1); 1 is IN (acc=in_data).
  - F HALT.
- Arithmetic is modulo 2^DATA_W.
  - ADD/ADDI: C = carry out.
  - SUB/SUBI: C = borrow (1 when acc < operand, unsigned).
  - SHL: C = old MSB. SHR: C = old LSB.
- Z = (new acc == 0) after every acc-writing op (1, 2–8, A, B, IN). All other ops keep Z.
- C changes only on 2, 3, 4, 5 and B; all other ops keep it.
- ST, NOP, JMP, JZ, OUT and HALT do not change acc.
- pc advances by +1 modulo 2^ADDR_W: 2^ADDR_W−1 wraps to 0. A taken jump overrides the increment.

## Timing
- 2 cycles per instruction (FETCH, EXEC). The first FETCH is the cycle after run is sampled high in IDLE.
- Effects of EXEC (acc, flags, regs, pc, out_data) are visible the cycle after EXEC.
- out_valid is high for exactly that one cycle. Back-to-back OUTs give strobes 2 cycles apart.
- halted rises the cycle after HALT's EXEC and falls in the cycle the FSM enters IDLE.
- rst in any state wins over everything: the next cycle shows reset values.
- Program memory write: prog_we at edge N makes the word readable from edge N+1.

## Test plan
- Load LDI 5; ADDI 3; OUT; HALT; run=1 → out_data=8 with a single out_valid pulse, then halted=1 with pc=3.
- LDI 0xFF; ADDI 1 → acc=0, Z=1, C=1. Then SUBI 1 → acc=0xFF, C=1 (borrow), Z=0.
- LDI 7; ST r2; LDI 1; ADD r2; SHL → acc=0x10, C=0. Then LDI 0x81; SHL → acc=0x02, C=1.
- Count-down loop: LDI 3; SUBI 1; JZ 4; JMP 1; OUT; HALT → exactly 3 SUBI executions and out_data=0. Also check JMP 15 followed by a straight-line NOP at address 15 wrapping pc to 0.
- Pause: drop run during the EXEC of instruction 2 → IDLE with pc=3, and prog_we writes accepted. Raise run → resumes at address 3.
- Assert rst mid-run → all outputs return to reset values next cycle, program memory contents are retained, and rerunning reproduces the first result.
